// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 8088 bus-hold arbiter family.
// Contents:
//   arb_state_t - phases of one bus loan (IDLE, WAIT_ACK, GRANT, GUARD, WAIT_REL)
//   rr_pick()   - round-robin pick of the first set request bit above a pointer,
//                 usable by any block that needs a behavioural round-robin search
//                 over up to MAX_REQ requesters.
package bus_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GRANT,
    GUARD,
    WAIT_REL
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Searches upward from ptr+1 with wrap over num_req requesters. The loop runs
  // from the farthest candidate to the nearest so the nearest set bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int                 num_req);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = num_req; k >= 1; k--) begin
      cand = (int'(ptr) + k) % num_req;
      if (req[3'(cand)]) begin
        res.found = 1'b1;
        res.idx   = 3'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotates the request vector so that the
// requester just after ptr sits at bit 0, priority-encodes the lowest set bit,
// then rotates the result back to an absolute index.
// Ports:
//   req    [NUM_REQ-1:0] in  - request vector
//   ptr    [PTR_W-1:0]   in  - index of the last served requester
//   found                out - at least one request is set
//   winner [PTR_W-1:0]   out - index of the chosen requester (valid when found)
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  logic [NUM_REQ-1:0] rotated;
  logic [PTR_W-1:0]   offset;

  always_comb begin
    rotated = '0;
    offset  = '0;
    found   = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[PTR_W'((int'(ptr) + 1 + i) % NUM_REQ)];
    end
    // Descending scan so the lowest set rotated bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = PTR_W'(i);
      end
    end
    winner = PTR_W'((int'(ptr) + 1 + int'(offset)) % NUM_REQ);
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Lends the 8088 local bus to one of NUM_REQ external masters via HOLD/HLDA.
// A round-robin winner is latched, HOLD is raised, and once the CPU answers
// with HLDA a one-hot grant plus AEN hand the bus to that master. A tenure
// limit preempts a master when others are waiting, and a guard window keeps
// HOLD high for GUARD_CYCLES after the grant drops so drivers never overlap.
// Ports:
//   CLK              in  - bus clock (CPU clock)
//   RESET_N          in  - asynchronous active-low reset
//   REQ  [NUM_REQ-1:0] in  - level bus requests
//   HLDA             in  - hold acknowledge from the CPU
//   HOLD             out - hold request to the CPU
//   GNT  [NUM_REQ-1:0] out - one-hot grant
//   AEN              out - external-master enable, equals |GNT
//   OWNER [PTR_W-1:0] out - current or last selected requester
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  NUM_REQ      = 2,
  parameter int  MAX_TENURE   = 64,
  parameter int  GUARD_CYCLES = 2,
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               HLDA,
  output logic               HOLD,
  output logic [NUM_REQ-1:0] GNT,
  output logic               AEN,
  output logic [PTR_W-1:0]   OWNER
);

  localparam int TEN_W = $clog2(MAX_TENURE);
  localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [TEN_W-1:0] TEN_MAX    = TEN_W'(MAX_TENURE - 1);
  localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(GUARD_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [TEN_W-1:0]   tenure_q, tenure_d;
  logic [GRD_W-1:0]   guard_q, guard_d;
  logic               hold_d, aen_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [PTR_W-1:0]   owner_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_winner;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_req;
  logic               others_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (REQ),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign owner_mask = NUM_REQ'(1) << OWNER;
  assign owner_req  = |(REQ & owner_mask);
  assign others_req = |(REQ & ~owner_mask);

  // Next-state and next-output logic. Every output is registered, so each
  // branch computes what the pins will show after the coming edge.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tenure_d = tenure_q;
    guard_d  = guard_q;
    hold_d   = HOLD;
    gnt_d    = GNT;
    aen_d    = AEN;
    owner_d  = OWNER;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = WAIT_ACK;
          hold_d  = 1'b1;
          owner_d = pick_winner;
        end
      end
      WAIT_ACK: begin
        // A requester giving up before HLDA ends the loan without a grant;
        // the pointer stays put so it keeps its turn.
        if (!owner_req) begin
          state_d = GUARD;
          guard_d = '0;
        end else if (HLDA) begin
          state_d  = GRANT;
          gnt_d    = owner_mask;
          aen_d    = 1'b1;
          tenure_d = '0;
        end
      end
      GRANT: begin
        if (tenure_q != TEN_MAX) begin
          tenure_d = tenure_q + TEN_W'(1);
        end
        // Release, tenure expiry with a competitor waiting, or the CPU
        // withdrawing HLDA all end the tenure the same way.
        if (!HLDA || !owner_req || ((tenure_q == TEN_MAX) && others_req)) begin
          state_d = GUARD;
          gnt_d   = '0;
          aen_d   = 1'b0;
          guard_d = '0;
          ptr_d   = OWNER;
        end
      end
      GUARD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = WAIT_REL;
          hold_d  = 1'b0;
        end else begin
          guard_d = guard_q + GRD_W'(1);
        end
      end
      WAIT_REL: begin
        if (!HLDA) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
        gnt_d   = '0;
        aen_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the bus handover immediately,
  // skipping the guard window.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      tenure_q <= '0;
      guard_q  <= '0;
      HOLD     <= 1'b0;
      GNT      <= '0;
      AEN      <= 1'b0;
      OWNER    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tenure_q <= tenure_d;
      guard_q  <= guard_d;
      HOLD     <= hold_d;
      GNT      <= gnt_d;
      AEN      <= aen_d;
      OWNER    <= owner_d;
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Self-checking bench for bus_hold_arbiter (NUM_REQ=2, MAX_TENURE=8,
// GUARD_CYCLES=2). A procedural model walks through each bus loan and is
// compared with the DUT on every falling clock edge; directed scenarios add
// hand-computed expectations on timing, order and counts.
module tb_bus_hold_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int MAX_TENURE   = 8;
  localparam int GUARD_CYCLES = 2;
  localparam int PTR_W        = 1;

  logic               CLK     = 1'b0;
  logic               RESET_N = 1'b1;
  logic [NUM_REQ-1:0] REQ     = '0;
  logic               HLDA    = 1'b0;
  logic               HOLD;
  logic [NUM_REQ-1:0] GNT;
  logic               AEN;
  logic [PTR_W-1:0]   OWNER;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic check_en = 1'b0;
  logic cpu_en   = 1'b1;

  bus_hold_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_TENURE   (MAX_TENURE),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .HLDA    (HLDA),
    .HOLD    (HOLD),
    .GNT     (GNT),
    .AEN     (AEN),
    .OWNER   (OWNER)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] req_value);
    REQ = req_value;
  endtask

  function automatic logic bit_of(input logic [NUM_REQ-1:0] vec, input int idx);
    logic [NUM_REQ-1:0] t;
    t = vec >> idx;
    return t[0];
  endfunction

  // CPU stand-in: HLDA mirrors HOLD three edges late.
  logic [2:0] hold_hist = '0;
  initial forever begin
    @(posedge CLK);
    #1;
    if (!RESET_N) hold_hist = '0;
    else hold_hist = {hold_hist[1:0], HOLD};
    HLDA = cpu_en & hold_hist[2];
  end

  // Behavioural model of one bus loan at a time.
  logic               m_hold  = 1'b0;
  logic [NUM_REQ-1:0] m_gnt   = '0;
  logic               m_aen   = 1'b0;
  int                 m_owner = 0;
  int                 m_last  = NUM_REQ - 1;
  logic               m_abort = 1'b0;

  always @(negedge RESET_N) begin
    m_abort = 1'b1;
    m_hold  = 1'b0;
    m_gnt   = '0;
    m_aen   = 1'b0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
  end

  task automatic model_loan();
    logic [NUM_REQ-1:0] r;
    int                 winner;
    int                 held;
    bit                 granted;
    do begin
      @(posedge CLK);
      if (m_abort) return;
      r = REQ;
    end while (r == '0);
    winner = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (winner < 0 && bit_of(r, (m_last + k) % NUM_REQ)) winner = (m_last + k) % NUM_REQ;
    end
    m_owner = winner;
    m_hold  = 1'b1;
    granted = 0;
    forever begin
      @(posedge CLK);
      if (m_abort) return;
      if (!bit_of(REQ, winner)) break;
      if (HLDA) begin
        granted = 1;
        break;
      end
    end
    if (granted) begin
      m_gnt = NUM_REQ'(1) << winner;
      m_aen = 1'b1;
      held  = 0;
      forever begin
        @(posedge CLK);
        if (m_abort) return;
        held++;
        if (!HLDA || !bit_of(REQ, winner) ||
            (held >= MAX_TENURE && (REQ & ~m_gnt) != '0)) break;
      end
      m_gnt  = '0;
      m_aen  = 1'b0;
      m_last = winner;
    end
    repeat (GUARD_CYCLES) begin
      @(posedge CLK);
      if (m_abort) return;
    end
    m_hold = 1'b0;
    do begin
      @(posedge CLK);
      if (m_abort) return;
    end while (HLDA);
  endtask

  initial begin
    forever begin
      wait (RESET_N === 1'b1);
      m_abort = 1'b0;
      model_loan();
    end
  end

  logic hlda_at_edge = 1'b0;
  always @(posedge CLK) hlda_at_edge <= HLDA;

  // Per-cycle comparison against the model plus output invariants.
  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("HOLD", 32'(HOLD), 32'(m_hold));
      checkOutput("GNT", 32'(GNT), 32'(m_gnt));
      checkOutput("AEN", 32'(AEN), 32'(m_aen));
      checkOutput("OWNER", 32'(OWNER), m_owner);
      checkOutput("gnt_onehot0", 32'($onehot0(GNT)), 1);
      checkOutput("aen_eq_or_gnt", 32'(AEN), 32'(|GNT));
      if (GNT != '0) checkOutput("gnt_needs_hold_hlda", 32'(HOLD && hlda_at_edge), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    applyStimulus('0);
    cyc(2);
    RESET_N = 1'b1;
  endtask

  // Waits for any current grant to end, then for the next one.
  task automatic wait_grant(input string name, output int idx);
    int budget;
    budget = 80;
    idx    = -1;
    while (GNT != '0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    while (GNT == '0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    checkOutput({name, "_timeout"}, 32'(GNT != '0), 1);
    if (GNT == 2'b01) idx = 0;
    else if (GNT == 2'b10) idx = 1;
  endtask

  int rr_order[4] = '{0, 1, 0, 1};

  initial begin
    int idx;
    int held;
    int dead;
    logic pulse;

    #2 RESET_N = 1'b0;
    cyc(3);
    checkOutput("reset_hold", 32'(HOLD), 0);
    checkOutput("reset_gnt", 32'(GNT), 0);
    checkOutput("reset_aen", 32'(AEN), 0);
    checkOutput("reset_owner", 32'(OWNER), 0);
    RESET_N  = 1'b1;
    check_en = 1'b1;

    // Single request with HLDA three cycles after HOLD.
    cyc(2);
    applyStimulus(2'b01);
    cyc(1);
    checkOutput("t1_hold_rise", 32'(HOLD), 1);
    checkOutput("t1_owner", 32'(OWNER), 0);
    cyc(2);
    checkOutput("t1_no_gnt_before_hlda", 32'(GNT), 0);
    cyc(1);
    checkOutput("t1_gnt", 32'(GNT), 32'h1);
    checkOutput("t1_aen", 32'(AEN), 1);
    cyc(4);
    applyStimulus(2'b00);
    cyc(1);
    checkOutput("t1_gnt_drop", 32'(GNT), 0);
    checkOutput("t1_guard_hold0", 32'(HOLD), 1);
    cyc(1);
    checkOutput("t1_guard_hold1", 32'(HOLD), 1);
    cyc(1);
    checkOutput("t1_hold_release", 32'(HOLD), 0);
    cyc(8);

    // Round robin with both requesting; each tenure ends after 6 cycles,
    // below the preemption limit.
    do_reset();
    cyc(1);
    applyStimulus(2'b11);
    for (int t = 0; t < 4; t++) begin
      wait_grant("rr_grant", idx);
      checkOutput("rr_order", idx, rr_order[t]);
      cyc(5);
      applyStimulus(REQ & ~(2'b01 << idx));
      cyc(1);
      applyStimulus(REQ | (2'b01 << idx));
      dead = 0;
      while (HOLD && GNT == '0 && dead < 20) begin
        dead++;
        cyc(1);
      end
      checkOutput("rr_guard_dead", dead, GUARD_CYCLES);
    end
    applyStimulus(2'b00);
    cyc(12);

    // Preemption after MAX_TENURE grant cycles.
    do_reset();
    cyc(1);
    applyStimulus(2'b01);
    wait_grant("pre_first", idx);
    checkOutput("pre_first_idx", idx, 0);
    held = 0;
    while (GNT == 2'b01 && held < 100) begin
      held++;
      if (held == 3) applyStimulus(2'b11);
      cyc(1);
    end
    checkOutput("pre_tenure", held, MAX_TENURE);
    wait_grant("pre_second", idx);
    checkOutput("pre_second_idx", idx, 1);
    cyc(3);
    applyStimulus(2'b01);
    wait_grant("pre_third", idx);
    checkOutput("pre_regrant_idx", idx, 0);
    applyStimulus(2'b00);
    cyc(12);

    // Sole requester is never preempted.
    do_reset();
    cyc(1);
    applyStimulus(2'b01);
    wait_grant("sole", idx);
    checkOutput("sole_idx", idx, 0);
    held = 0;
    for (int i = 0; i < 200; i++) begin
      if (GNT == 2'b01) held++;
      cyc(1);
    end
    checkOutput("sole_no_preempt", held, 200);
    applyStimulus(2'b00);
    cyc(12);

    // Abort before HLDA: no grant, pointer unchanged.
    do_reset();
    cpu_en = 1'b0;
    cyc(1);
    applyStimulus(2'b01);
    cyc(1);
    checkOutput("abort_hold_rise", 32'(HOLD), 1);
    pulse = |GNT;
    cyc(1);
    applyStimulus(2'b00);
    pulse = pulse | (|GNT);
    cyc(1);
    pulse = pulse | (|GNT);
    checkOutput("abort_guard0", 32'(HOLD), 1);
    cyc(1);
    pulse = pulse | (|GNT);
    checkOutput("abort_guard1", 32'(HOLD), 1);
    cyc(1);
    pulse = pulse | (|GNT);
    checkOutput("abort_hold_release", 32'(HOLD), 0);
    checkOutput("abort_no_gnt", 32'(pulse), 0);
    cyc(4);
    cpu_en = 1'b1;
    cyc(3);
    applyStimulus(2'b11);
    wait_grant("abort_next", idx);
    checkOutput("abort_next_idx", idx, 0);
    applyStimulus(2'b00);
    cyc(12);

    // Asynchronous reset in the middle of a grant.
    applyStimulus(2'b01);
    wait_grant("rst_pre", idx);
    checkOutput("rst_pre_idx", idx, 0);
    cyc(3);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("rst_async_hold", 32'(HOLD), 0);
    checkOutput("rst_async_gnt", 32'(GNT), 0);
    checkOutput("rst_async_aen", 32'(AEN), 0);
    cyc(2);
    applyStimulus(2'b10);
    RESET_N = 1'b1;
    wait_grant("rst_post", idx);
    checkOutput("rst_post_idx", idx, 1);
    checkOutput("rst_post_owner", 32'(OWNER), 1);
    applyStimulus(2'b00);
    cyc(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
